barrier_collision_detector: RTL and testbench
=============================================

// Module: barrier_collision_detector
// PURPOSE
//  Producer end of the barrier_hit / out_of_lives link to the lives display compositor.
//  - Counts player-sprite vs barrier-sprite pixel overlaps during each video frame.
//  - At each frame boundary (rising edge of i_v_sync) decides whether a collision happened.
//  - On a collision, emits one clean barrier_hit pulse, then blocks further hits for a
//    fixed number of frames (invulnerability window).
//  - Freezes once the compositor reports out_of_lives.
// PARAMETERS
//  OVERLAP_MIN      4   overlapping pixels in one frame needed to register a collision
//  COOLDOWN_FRAMES  60  frames of invulnerability after a hit (must be >= 1)
//  PULSE_CYCLES     4   width of o_barrier_hit, in i_clk cycles (must be >= 1)
//  BLINK_SHIFT      3   o_blink toggles every 2**BLINK_SHIFT frames during cooldown
// PORTS
//  i_clk            in   1   pixel clock; the only clock
//  i_rst_n          in   1   asynchronous, active-low reset
//  i_pix_valid      in   1   high during active video
//  i_v_sync         in   1   vertical sync, level, synchronous to i_clk
//  i_player_hit     in   1   player sprite has an opaque pixel at the current position
//  i_barrier_hit    in   1   barrier sprite has an opaque pixel at the current position
//  i_out_of_lives   in   1   level input from the lives compositor
//  i_game_start     in   1   one-cycle restart request
//  o_barrier_hit    out  1   collision pulse to the lives compositor
//  o_invuln         out  1   high during the cooldown window
//  o_blink          out  1   player-sprite blink enable during cooldown
//  o_game_over      out  1   high in state GAME_OVER
// BEHAVIOUR
//  Reset values: all outputs 0, state ARMED, overlap count 0, pulse and frame counters 0.
//  Frame edge:
//   - fedge = i_v_sync high now and low on the previous cycle (registered sample).
//  Overlap counter:
//   - Width is $clog2(OVERLAP_MIN+1); saturates at OVERLAP_MIN.
//   - Increments when i_pix_valid & i_player_hit & i_barrier_hit.
//   - On fedge, the decision uses the registered count; a qualifying pixel in that same
//     cycle does not count for the ending frame.
//   - On fedge, the count reloads to 1 if the same-cycle pixel qualifies, else 0.
//  FSM states: ARMED, HIT, COOLDOWN, GAME_OVER.
//   ARMED -> HIT
//    - On fedge with count == OVERLAP_MIN (the saturated value).
//    - Next cycle: o_barrier_hit = 1, pulse counter = PULSE_CYCLES-1.
//   HIT
//    - o_barrier_hit stays high for exactly PULSE_CYCLES cycles, o_invuln = 1.
//    - Then -> COOLDOWN with the frame counter loaded to COOLDOWN_FRAMES.
//    - A fedge during HIT decrements the frame counter, so frames are not lost.
//   COOLDOWN
//    - Frame counter decrements on every fedge. Overlaps are counted but ignored.
//    - o_invuln = 1; o_blink = frame_counter[BLINK_SHIFT].
//    - On the fedge where the counter reaches 0: -> ARMED, o_invuln = 0, o_blink = 0,
//      overlap count reloaded per the fedge rule.
//   GAME_OVER
//    - Entered from any state on the cycle after i_out_of_lives is seen high; this rule
//      has top priority.
//    - An in-flight pulse is cut short: o_barrier_hit = 0 in GAME_OVER.
//    - o_invuln = 0, o_blink = 0, o_game_over = 1.
//    - Exit to ARMED on i_game_start only while i_out_of_lives is low; all counters clear.
//   i_game_start outside GAME_OVER: -> ARMED, counters clear, pulse aborted.
//  Priority when events coincide: i_out_of_lives > i_game_start > fedge > pixel count.
//  Reset mid-pulse: o_barrier_hit drops at once (asynchronous); no further pulse follows.
//  Latency: fedge to o_barrier_hit rising edge is exactly 1 cycle.
// STRUCTURE
//  game_pkg:
//   - typedef enum logic [1:0] collide_state_t {ARMED, HIT, COOLDOWN, GAME_OVER}.
//   - Default constants for OVERLAP_MIN, COOLDOWN_FRAMES and PULSE_CYCLES.
//  Sub-module vsync_edge_detect (i_clk, i_rst_n, i_v_sync -> o_rise):
//   - One flop plus an AND gate; shared with the other frame-rate logic.
//  This block holds the FSM, the overlap counter, the pulse counter and the frame counter.
// TESTING
//  1. 5 overlap pixels in frame N -> o_barrier_hit high for 4 cycles, starting 1 cycle
//     after frame N's fedge.
//  2. Only 3 overlap pixels (OVERLAP_MIN-1) -> no pulse; the count restarts at 0 next frame.
//  3. Overlap on every frame after a hit -> no second pulse for 60 fedges; a pulse on the
//     61st fedge; o_blink toggles every 8 frames.
//  4. i_out_of_lives rises during cycle 2 of a pulse -> o_barrier_hit low on the next
//     cycle; o_game_over = 1; i_game_start ignored while i_out_of_lives = 1.
//  5. Qualifying pixel in the same cycle as the fedge with count = 3 -> no hit; next-frame
//     count starts at 1.
//  6. i_rst_n low mid-COOLDOWN -> all outputs 0 at once; after release, ARMED with
//     count = 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and default tuning constants for the barrier collision logic.
package game_pkg;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    HIT       = 2'd1,
    COOLDOWN  = 2'd2,
    GAME_OVER = 2'd3
  } collide_state_t;

  localparam int OVERLAP_MIN_DEF     = 4;
  localparam int COOLDOWN_FRAMES_DEF = 60;
  localparam int PULSE_CYCLES_DEF    = 4;
  localparam int BLINK_SHIFT_DEF     = 3;

endpackage

// File: rtl/barrier_collision_detector_if.sv
// Sprite/frame inputs and lives-link outputs of the collision detector.
interface barrier_collision_detector_if;
  logic i_pix_valid;
  logic i_v_sync;
  logic i_player_hit;
  logic i_barrier_hit;
  logic i_out_of_lives;
  logic i_game_start;
  logic o_barrier_hit;
  logic o_invuln;
  logic o_blink;
  logic o_game_over;

  modport master (
    output i_pix_valid, i_v_sync, i_player_hit, i_barrier_hit, i_out_of_lives, i_game_start,
    input  o_barrier_hit, o_invuln, o_blink, o_game_over
  );

  modport slave (
    input  i_pix_valid, i_v_sync, i_player_hit, i_barrier_hit, i_out_of_lives, i_game_start,
    output o_barrier_hit, o_invuln, o_blink, o_game_over
  );
endinterface

// File: rtl/vsync_edge_detect.sv
// Rising-edge detector on vertical sync: one flop plus an AND gate.
module vsync_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_v_sync,
  output logic o_rise
);
  logic v_sync_q, v_sync_d;

  // next sample is simply the current level
  always_comb v_sync_d = i_v_sync;

  // previous-cycle sample of v_sync
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) v_sync_q <= 1'b0;
    else          v_sync_q <= v_sync_d;
  end

  assign o_rise = i_v_sync & ~v_sync_q;
endmodule

// File: rtl/barrier_collision_detector.sv
// Per-frame player/barrier overlap counter, hit pulse generator and
// invulnerability window, frozen while the lives compositor reports game over.
module barrier_collision_detector
  import game_pkg::*;
#(
  parameter int OVERLAP_MIN     = OVERLAP_MIN_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int PULSE_CYCLES    = PULSE_CYCLES_DEF,
  parameter int BLINK_SHIFT     = BLINK_SHIFT_DEF
) (
  input logic i_clk,
  input logic i_rst_n,
  barrier_collision_detector_if.slave bus
);
  localparam int CW     = $clog2(OVERLAP_MIN + 1);
  localparam int FW_RAW = $clog2(COOLDOWN_FRAMES + 1);
  // frame counter must be wide enough to expose the blink bit
  localparam int FW     = (FW_RAW > BLINK_SHIFT) ? FW_RAW : BLINK_SHIFT + 1;
  localparam int PW     = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_MAX    = CW'(OVERLAP_MIN);
  localparam logic [FW-1:0] FRAME_LOAD = FW'(COOLDOWN_FRAMES);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);

  collide_state_t  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pulse_q, pulse_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            fedge;
  logic            qual;

  vsync_edge_detect u_vsync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_v_sync(bus.i_v_sync),
    .o_rise  (fedge)
  );

  assign qual = bus.i_pix_valid & bus.i_player_hit & bus.i_barrier_hit;

  // next-state: out_of_lives > game_start > frame edge > pixel count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    frame_d = frame_q;
    if (bus.i_out_of_lives) begin
      state_d = GAME_OVER;
      pulse_d = '0;
    end else if (bus.i_game_start) begin
      state_d = ARMED;
      cnt_d   = '0;
      pulse_d = '0;
      frame_d = '0;
    end else begin
      // a pixel on the edge cycle belongs to the new frame
      if (fedge)                        cnt_d = qual ? CW'(1) : '0;
      else if (qual && cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);

      case (state_q)
        ARMED: begin
          if (fedge && cnt_q == CNT_MAX) begin
            state_d = HIT;
            pulse_d = PULSE_LOAD;
            frame_d = FRAME_LOAD;
          end
        end
        HIT: begin
          // frames passing during the pulse still count toward cooldown
          if (fedge && frame_q != '0) frame_d = frame_q - FW'(1);
          if (pulse_q == '0) state_d = (frame_d == '0) ? ARMED : COOLDOWN;
          else               pulse_d = pulse_q - PW'(1);
        end
        COOLDOWN: begin
          if (fedge) begin
            if (frame_q <= FW'(1)) begin
              state_d = ARMED;
              frame_d = '0;
            end else begin
              frame_d = frame_q - FW'(1);
            end
          end
        end
        GAME_OVER: ;
        default: state_d = ARMED;
      endcase
    end
  end

  // state and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARMED;
      cnt_q   <= '0;
      pulse_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      frame_q <= frame_d;
    end
  end

  // outputs decode straight from state so reset clears them immediately
  assign bus.o_barrier_hit = (state_q == HIT);
  assign bus.o_invuln      = (state_q == HIT) || (state_q == COOLDOWN);
  assign bus.o_blink       = (state_q == COOLDOWN) && frame_q[BLINK_SHIFT];
  assign bus.o_game_over   = (state_q == GAME_OVER);
endmodule

// File: tb/tb_barrier_collision_detector.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor checks them.
module tb_barrier_collision_detector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  barrier_collision_detector_if bus();

  barrier_collision_detector dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    int start;
    int width;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t e;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic prev_hit = 1'b0;
  int st = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: measure each o_barrier_hit pulse and match against the queue
  always @(negedge clk) begin
    if (bus.o_barrier_hit && !prev_hit) st = cyc;
    if (!bus.o_barrier_hit && prev_hit) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("pulse_start", st, e.start);
        chk("pulse_width", cyc - st, e.width);
      end
    end
    prev_hit = bus.o_barrier_hit;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 10 active pixels (player everywhere, barrier on the first n_ovl), then a sync pulse
  task automatic run_frame(input int n_ovl, input bit edge_qual, input int exp_w, input bit kill);
    pulse_t p;
    for (int i = 0; i < 10; i++) begin
      bus.i_pix_valid   = 1'b1;
      bus.i_player_hit  = 1'b1;
      bus.i_barrier_hit = (i < n_ovl);
      tick();
    end
    bus.i_v_sync      = 1'b1;
    bus.i_pix_valid   = edge_qual;
    bus.i_player_hit  = edge_qual;
    bus.i_barrier_hit = edge_qual;
    if (exp_w > 0) begin
      p.start = cyc + 1;
      p.width = exp_w;
      exp_q.push_back(p);
    end
    tick();
    bus.i_pix_valid   = 1'b0;
    bus.i_player_hit  = 1'b0;
    bus.i_barrier_hit = 1'b0;
    tick();
    if (kill) bus.i_out_of_lives = 1'b1;
    bus.i_v_sync = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.i_pix_valid = 0; bus.i_v_sync = 0; bus.i_player_hit = 0;
    bus.i_barrier_hit = 0; bus.i_out_of_lives = 0; bus.i_game_start = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit", bus.o_barrier_hit, 0);
    chk("rst_invuln", bus.o_invuln, 0);
    chk("rst_blink", bus.o_blink, 0);
    chk("rst_game_over", bus.o_game_over, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // below threshold twice: count must restart each frame
    run_frame(3, 0, 0, 0);
    run_frame(3, 0, 0, 0);

    // edge-cycle pixel belongs to next frame: 3 -> no hit, then 1+3 -> hit
    run_frame(3, 1, 0, 0);
    run_frame(3, 0, 4, 0);
    chk("t5_hit_level", bus.o_barrier_hit, 1);
    chk("t5_invuln_hit", bus.o_invuln, 1);
    repeat (4) tick();
    chk("t5_invuln_cool", bus.o_invuln, 1);
    chk("t5_blink_60", bus.o_blink, 1);
    bus.i_game_start = 1'b1; tick(); bus.i_game_start = 1'b0;
    chk("start_invuln", bus.o_invuln, 0);
    chk("start_blink", bus.o_blink, 0);

    // hit, then 60 cooldown frames with overlap every frame
    for (int k = 0; k <= 60; k++) begin
      run_frame(5, 0, (k == 0) ? 4 : 0, 0);
      if (k == 0) begin
        chk("cd_invuln_hit", bus.o_invuln, 1);
        chk("cd_blink_hit", bus.o_blink, 0);
      end else if (k < 60) begin
        chk("cd_invuln", bus.o_invuln, 1);
        chk("cd_blink", bus.o_blink, ((60 - k) >> 3) & 1);
      end else begin
        chk("cd_end_invuln", bus.o_invuln, 0);
        chk("cd_end_blink", bus.o_blink, 0);
      end
    end

    // 61st frame hits; out_of_lives cuts the pulse after 2 cycles
    run_frame(5, 0, 2, 1);
    chk("go_flag", bus.o_game_over, 1);
    chk("go_hit", bus.o_barrier_hit, 0);
    chk("go_invuln", bus.o_invuln, 0);
    chk("go_blink", bus.o_blink, 0);
    bus.i_game_start = 1'b1; tick(); bus.i_game_start = 1'b0;
    chk("go_start_blocked", bus.o_game_over, 1);
    bus.i_out_of_lives = 1'b0; tick();
    chk("go_hold", bus.o_game_over, 1);
    bus.i_game_start = 1'b1; tick(); bus.i_game_start = 1'b0;
    chk("go_exit", bus.o_game_over, 0);

    // reset in the middle of cooldown with a saturated overlap count
    run_frame(5, 0, 4, 0);
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 0, 0);
    chk("t6_invuln", bus.o_invuln, 1);
    chk("t6_blink", bus.o_blink, 1);
    for (int i = 0; i < 4; i++) begin
      bus.i_pix_valid = 1'b1; bus.i_player_hit = 1'b1; bus.i_barrier_hit = 1'b1;
      tick();
    end
    bus.i_pix_valid = 1'b0; bus.i_player_hit = 1'b0; bus.i_barrier_hit = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_hit", bus.o_barrier_hit, 0);
    chk("t6_rst_invuln", bus.o_invuln, 0);
    chk("t6_rst_blink", bus.o_blink, 0);
    chk("t6_rst_game_over", bus.o_game_over, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    run_frame(0, 0, 0, 0);
    chk("t6_post_invuln", bus.o_invuln, 0);

    repeat (8) tick();
    chk("pending_pulses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
